wts_timer: RTL and testbench



---
 rtl/wts_timer.sv | 126 ++++++++++++
 tb/tb_wts_timer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_timer.sv
// Dual interval timer / interrupt source for the wave-table sound cartridge.
// Two independent one-shot/repeat countdowns; status reads clear the flags.
module wts_timer #(
  parameter int unsigned PRESCALE = 2048,
  parameter int unsigned PERIOD_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdata_en,
  output logic       irq
);

  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned CNT_W = PERIOD_W + PS_W;

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q  [2];
  state_e               state_d  [2];
  logic [CNT_W-1:0]     cnt_q    [2];
  logic [CNT_W-1:0]     cnt_d    [2];
  logic [PERIOD_W-1:0]  period_q [2];
  logic [PERIOD_W-1:0]  period_d [2];
  logic [1:0]           mode_q, mode_d;
  logic [1:0]           flag_q, flag_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 rdata_en_q, rdata_en_d;
  logic                 irq_q, irq_d;

  logic [1:0]           fire;
  logic [1:0]           tsel;
  logic                 sel;
  logic [7:0]           rd_val;

  assign sel  = address[1];
  assign tsel = address[1] ? 2'b10 : 2'b01;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    mode_d     = mode_q;
    flag_d     = flag_q;
    fire       = '0;
    rd_val     = '0;

    for (int unsigned i = 0; i < 2; i++) begin
      fire[i] = (state_q[i] == RUN) && (cnt_q[i] == '0);

      case (state_q[i])
        IDLE: ;
        RUN: begin
          if (cnt_q[i] == '0) begin
            if (mode_q[i]) state_d[i] = IDLE;
            else           cnt_d[i]   = {period_q[i], {PS_W{1'b0}}};
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase

      // A control write overrides whatever the countdown did this cycle
      if (wr && !address[0] && tsel[i]) begin
        if (wdata[7]) begin
          state_d[i]  = RUN;
          mode_d[i]   = wdata[6];
          period_d[i] = wdata[PERIOD_W-1:0];
          cnt_d[i]    = {wdata[PERIOD_W-1:0], {PS_W{1'b0}}};
        end else begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      end

      // Set from a fire takes priority over clear-on-read
      if (fire[i])                           flag_d[i] = 1'b1;
      else if (rd && address[0] && tsel[i])  flag_d[i] = 1'b0;
    end

    if (address[0]) begin
      rd_val[7] = ~flag_q[sel];
      rd_val[6] = (state_q[sel] == RUN);
    end else begin
      rd_val[7]            = (state_q[sel] == RUN);
      rd_val[6]            = mode_q[sel];
      rd_val[PERIOD_W-1:0] = period_q[sel];
    end
  end

  assign rdata_d    = rd ? rd_val : rdata_q;
  assign rdata_en_d = rd;
  assign irq_d      = |flag_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= '{default: IDLE};
      cnt_q      <= '{default: '0};
      period_q   <= '{default: '0};
      mode_q     <= '0;
      flag_q     <= '0;
      rdata_q    <= '0;
      rdata_en_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      flag_q     <= flag_d;
      rdata_q    <= rdata_d;
      rdata_en_q <= rdata_en_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata    = rdata_q;
  assign rdata_en = rdata_en_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_wts_timer.sv
// Directed self-checking bench for wts_timer; inputs change and outputs are
// sampled on the falling clock edge.
module tb_wts_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic [1:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_en;
  logic       irq;

  int checks = 0;
  int passed = 0;

  wts_timer #(.PRESCALE(2048), .PERIOD_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdata_en (rdata_en),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // All stimulus tasks start and end right after a falling edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    wr = 1'b1; address = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; wdata = 8'h00;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [7:0] d, output logic en);
    rd = 1'b1; address = a;
    @(negedge clk);
    rd = 1'b0;
    d  = rdata;
    en = rdata_en;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic       en;
    checks++;
    if ({rdata, rdata_en, irq} !== 10'h000) $display("FAIL reset_outputs: got rdata=%h en=%b irq=%b expected 00/0/0", rdata, rdata_en, irq);
    else passed++;
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h80 || en !== 1'b1) $display("FAIL reset_stat1: got %h en=%b expected 80 en=1", d, en);
    else passed++;
    do_read(2'd3, d, en);
    checks++;
    if (d !== 8'h80 || en !== 1'b1) $display("FAIL reset_stat2: got %h en=%b expected 80 en=1", d, en);
    else passed++;
    do_read(2'd0, d, en);
    checks++;
    if (d !== 8'h00) $display("FAIL reset_ctrl1: got %h expected 00", d);
    else passed++;
    @(negedge clk);
    checks++;
    if (rdata_en !== 1'b0 || irq !== 1'b0) $display("FAIL reset_idle: got en=%b irq=%b expected 0/0", rdata_en, irq);
    else passed++;
  endtask

  task automatic test_oneshot_p0;
    logic [7:0] d;
    logic       en;
    do_write(2'd0, 8'hC0);
    checks++;
    if (irq !== 1'b0) $display("FAIL p0_latency_early: got irq=%b expected 0", irq);
    else passed++;
    do_write(2'd2, 8'hC0);
    checks++;
    if (irq !== 1'b1) $display("FAIL p0_irq: got irq=%b expected 1", irq);
    else passed++;
    @(negedge clk);
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h00) $display("FAIL p0_stat1: got %h expected 00", d);
    else passed++;
    checks++;
    if (irq !== 1'b1) $display("FAIL p0_irq_flag2_only: got irq=%b expected 1", irq);
    else passed++;
    do_read(2'd3, d, en);
    checks++;
    if (d !== 8'h00 || irq !== 1'b0) $display("FAIL p0_stat2: got %h irq=%b expected 00 irq=0", d, irq);
    else passed++;
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h80) $display("FAIL p0_reread1: got %h expected 80", d);
    else passed++;
    do_read(2'd3, d, en);
    checks++;
    if (d !== 8'h80) $display("FAIL p0_reread2: got %h expected 80", d);
    else passed++;
    do_read(2'd0, d, en);
    checks++;
    if (d !== 8'h40) $display("FAIL p0_ctrl1_readback: got %h expected 40", d);
    else passed++;
  endtask

  task automatic test_repeat;
    logic [7:0] d;
    logic       en;
    do_write(2'd0, 8'h82);
    wait_cycles(4096);
    checks++;
    if (irq !== 1'b0) $display("FAIL rep_first_early: got irq=%b expected 0", irq);
    else passed++;
    wait_cycles(1);
    checks++;
    if (irq !== 1'b1) $display("FAIL rep_first_fire: got irq=%b expected 1", irq);
    else passed++;
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h40 || irq !== 1'b0) $display("FAIL rep_stat1: got %h irq=%b expected 40 irq=0", d, irq);
    else passed++;
    wait_cycles(4095);
    checks++;
    if (irq !== 1'b0) $display("FAIL rep_second_early: got irq=%b expected 0", irq);
    else passed++;
    wait_cycles(1);
    checks++;
    if (irq !== 1'b1) $display("FAIL rep_second_fire: got irq=%b expected 1", irq);
    else passed++;
  endtask

  // Continues from test_repeat: counter was reloaded at the edge irq rose.
  task automatic test_fire_read_collision;
    logic [7:0] d;
    logic       en;
    wait_cycles(4096);
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h40 || irq !== 1'b1) $display("FAIL coll_read: got %h irq=%b expected 40 irq=1", d, irq);
    else passed++;
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h40 || irq !== 1'b0) $display("FAIL coll_reread: got %h irq=%b expected 40 irq=0", d, irq);
    else passed++;
    do_write(2'd0, 8'h00);
    wait_cycles(5000);
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h80 || irq !== 1'b0) $display("FAIL rep_disabled: got %h irq=%b expected 80 irq=0", d, irq);
    else passed++;
  endtask

  task automatic test_restart;
    logic [7:0] d;
    logic       en;
    do_write(2'd0, 8'hC1);
    wait_cycles(1000);
    do_write(2'd0, 8'hC1);
    wait_cycles(2048);
    checks++;
    if (irq !== 1'b0) $display("FAIL restart_early: got irq=%b expected 0", irq);
    else passed++;
    wait_cycles(1);
    checks++;
    if (irq !== 1'b1) $display("FAIL restart_fire: got irq=%b expected 1", irq);
    else passed++;
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h00 || irq !== 1'b0) $display("FAIL restart_stat1: got %h irq=%b expected 00 irq=0", d, irq);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic       en;
    do_write(2'd0, 8'hC1);
    wait_cycles(2048);
    do_write(2'd0, 8'hC1);
    checks++;
    if (irq !== 1'b1) $display("FAIL b2b_fire_kept: got irq=%b expected 1", irq);
    else passed++;
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h40) $display("FAIL b2b_restart_active: got %h expected 40", d);
    else passed++;
    wait_cycles(2047);
    checks++;
    if (irq !== 1'b0) $display("FAIL b2b_second_early: got irq=%b expected 0", irq);
    else passed++;
    wait_cycles(1);
    checks++;
    if (irq !== 1'b1) $display("FAIL b2b_second_fire: got irq=%b expected 1", irq);
    else passed++;
    do_read(2'd1, d, en);
    checks++;
    if (d !== 8'h00) $display("FAIL b2b_stat1: got %h expected 00", d);
    else passed++;
  endtask

  task automatic test_reset_midcount;
    logic [7:0] d;
    logic       en;
    int         irq_seen;
    do_write(2'd0, 8'hC0);
    do_write(2'd2, 8'hC3);
    wait_cycles(3000);
    do_read(2'd0, d, en);
    checks++;
    if (irq !== 1'b1 || en !== 1'b1) $display("FAIL pre_reset: got irq=%b en=%b expected 1/1", irq, en);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rdata, rdata_en, irq} !== 10'h000) $display("FAIL async_reset: got rdata=%h en=%b irq=%b expected 00/0/0", rdata, rdata_en, irq);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    irq_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) irq_seen++;
    end
    checks++;
    if (irq_seen != 0) $display("FAIL post_reset_quiet: got %0d cycles with irq expected 0", irq_seen);
    else passed++;
    do_read(2'd3, d, en);
    checks++;
    if (d !== 8'h80) $display("FAIL post_reset_stat2: got %h expected 80", d);
    else passed++;
    do_read(2'd2, d, en);
    checks++;
    if (d !== 8'h00) $display("FAIL post_reset_ctrl2: got %h expected 00", d);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; address = 2'd0; wdata = 8'h00;
    repeat (3) @(negedge clk);
    test_reset_pre: begin end
    checks++;
    if ({rdata, rdata_en, irq} !== 10'h000) $display("FAIL in_reset: got rdata=%h en=%b irq=%b expected 00/0/0", rdata, rdata_en, irq);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_oneshot_p0;
    test_repeat;
    test_fire_read_collision;
    test_restart;
    test_back_to_back;
    test_reset_midcount;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
